// File: rtl/tt_um_haz_detect_if.sv
// tt_um_haz_detect_if: issue/resolution inputs and hazard indications of the detector
interface tt_um_haz_detect_if;
  logic       in_valid;
  logic [2:0] in_rd;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  logic       in_load;
  logic       in_mul;
  logic       in_branch;
  logic       in_pred;
  logic       res_valid;
  logic       res_taken;
  logic       freeze;
  logic       flush;
  logic       data;
  logic       fwrd;
  logic       str;
  logic       ctrl;
  logic       branch;
  logic       crct;
  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_load, in_mul, in_branch, in_pred,
           res_valid, res_taken, freeze, flush,
    input  data, fwrd, str, ctrl, branch, crct
  );
  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_load, in_mul, in_branch, in_pred,
           res_valid, res_taken, freeze, flush,
    output data, fwrd, str, ctrl, branch, crct
  );
endinterface

// File: rtl/tt_um_haz_detect.sv
// tt_um_haz_detect: data, structural and control hazard detector over an EX/MEM/WB shadow pipeline
module tt_um_haz_detect #(
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst_n,
  tt_um_haz_detect_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } stage_t;
  stage_t     ex_q, ex_d, mem_q, mem_d, wb_unused_q, wb_unused_d;
  logic [2:0] busy_q, busy_d;
  logic       pend_q, pend_d, pred_q, pred_d;
  logic       data_q, data_d, fwrd_q, fwrd_d, str_q, str_d;
  logic       ctrl_q, ctrl_d, branch_q, branch_d, crct_q, crct_d;
  logic       acc, ex1, ex2, mem1, mem2, rslv, take;
  always_comb begin
    acc = bus.in_valid & ~bus.freeze & ~bus.flush;
    ex1 = ex_q.v && bus.in_rs1 != 3'd0 && bus.in_rs1 == ex_q.rd;
    ex2 = ex_q.v && bus.in_rs2 != 3'd0 && bus.in_rs2 == ex_q.rd;
    mem1 = mem_q.v && bus.in_rs1 != 3'd0 && bus.in_rs1 == mem_q.rd;
    mem2 = mem_q.v && bus.in_rs2 != 3'd0 && bus.in_rs2 == mem_q.rd;
    data_d = bus.in_valid & (ex1 | ex2 | mem1 | mem2);
    fwrd_d = data_d & ~(ex_q.ld & (ex1 | ex2));
    ex_d = bus.flush ? stage_t'(0) : acc ? stage_t'({1'b1, bus.in_rd, bus.in_load}) : stage_t'(0);
    mem_d = bus.flush ? stage_t'(0) : ex_q;
    wb_unused_d = bus.flush ? stage_t'(0) : mem_q;
    busy_d = (acc & bus.in_mul) ? 3'(MUL_LAT - 1) : (busy_q == 3'd0) ? 3'd0 : busy_q - 3'd1;
    str_d = bus.in_valid & bus.in_mul & (busy_q != 3'd0);
    rslv = pend_q & bus.res_valid;
    // a new branch may take over the tracker only when it is free or freeing this cycle
    take = acc & bus.in_branch & (~pend_q | rslv);
    pend_d = bus.flush ? 1'b0 : take ? 1'b1 : rslv ? 1'b0 : pend_q;
    pred_d = take ? bus.in_pred : pred_q;
    ctrl_d = pend_d | rslv;
    branch_d = rslv;
    crct_d = rslv & (bus.res_taken == pred_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_unused_q <= '0;
      busy_q <= '0;
      pend_q <= 1'b0;
      pred_q <= 1'b0;
      data_q <= 1'b0;
      fwrd_q <= 1'b0;
      str_q <= 1'b0;
      ctrl_q <= 1'b0;
      branch_q <= 1'b0;
      crct_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_unused_q <= wb_unused_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      pred_q <= pred_d;
      data_q <= data_d;
      fwrd_q <= fwrd_d;
      str_q <= str_d;
      ctrl_q <= ctrl_d;
      branch_q <= branch_d;
      crct_q <= crct_d;
    end
  end
  assign bus.data = data_q;
  assign bus.fwrd = fwrd_q;
  assign bus.str = str_q;
  assign bus.ctrl = ctrl_q;
  assign bus.branch = branch_q;
  assign bus.crct = crct_q;
endmodule

// File: tb/tb_tt_um_haz_detect.sv
// tb_tt_um_haz_detect: directed and random checks against a cycle-history reference model
module tb_tt_um_haz_detect;
  localparam int MUL_LAT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tt_um_haz_detect_if u ();
  tt_um_haz_detect #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(u));
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 2;
  int kill = -1;
  int last_mul = -1000;
  bit pend = 0;
  bit ppred = 0;
  bit h_acc [4096];
  bit [2:0] h_rd [4096];
  bit h_ld [4096];
  function automatic bit alive(int i);
    return i >= 0 && h_acc[i] && kill <= i;
  endfunction
  function automatic bit hit(int i, bit [2:0] rs);
    return rs != 3'd0 && alive(i) && h_rd[i] == rs;
  endfunction
  task automatic chk(string tag, logic o, logic x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b cyc=%0d", tag, o, x, cyc);
    end
  endtask
  task automatic clr();
    u.in_valid = 0; u.in_rd = 0; u.in_rs1 = 0; u.in_rs2 = 0; u.in_load = 0; u.in_mul = 0;
    u.in_branch = 0; u.in_pred = 0; u.res_valid = 0; u.res_taken = 0; u.freeze = 0; u.flush = 0;
  endtask
  task automatic tick();
    bit a, d, f, s, c, b, k, rs, take;
    bit [2:0] r1, r2;
    r1 = u.in_rs1;
    r2 = u.in_rs2;
    a = rst_n && u.in_valid && !u.freeze && !u.flush;
    if (!rst_n) begin
      {d, f, s, c, b, k} = '0;
      kill = cyc; last_mul = -1000; pend = 0;
    end else begin
      d = u.in_valid && (hit(cyc-1, r1) || hit(cyc-1, r2) || hit(cyc-2, r1) || hit(cyc-2, r2));
      f = d && !(h_ld[cyc-1] && (hit(cyc-1, r1) || hit(cyc-1, r2)));
      s = u.in_valid && u.in_mul && (cyc - last_mul < MUL_LAT);
      if (a && u.in_mul) last_mul = cyc;
      rs = pend && u.res_valid;
      b = rs;
      k = rs && (u.res_taken == ppred);
      take = a && u.in_branch && (!pend || rs);
      if (take) ppred = u.in_pred;
      pend = u.flush ? 0 : take ? 1 : rs ? 0 : pend;
      c = pend || rs;
      if (u.flush) kill = cyc;
    end
    h_acc[cyc] = a; h_rd[cyc] = u.in_rd; h_ld[cyc] = u.in_load;
    @(posedge clk);
    #1;
    chk("data", u.data, d);
    chk("fwrd", u.fwrd, f);
    chk("str", u.str, s);
    chk("ctrl", u.ctrl, c);
    chk("branch", u.branch, b);
    chk("crct", u.crct, k);
    cyc++;
  endtask
  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    chk("rst_data", u.data, 1'b0);
    chk("rst_ctrl", u.ctrl, 1'b0);
    rst_n = 1;
    clr(); u.in_valid = 1; u.in_rd = 3; u.in_load = 1; tick();
    clr(); u.in_valid = 1; u.in_rs1 = 3; tick();
    chk("ld_use_data", u.data, 1'b1);
    chk("ld_use_fwrd", u.fwrd, 1'b0);
    clr(); tick(); tick();
    clr(); u.in_valid = 1; u.in_rd = 3; tick();
    clr(); u.in_valid = 1; u.in_rs1 = 3; tick();
    chk("alu_use_data", u.data, 1'b1);
    chk("alu_use_fwrd", u.fwrd, 1'b1);
    clr(); tick(); tick();
    clr(); u.in_valid = 1; u.in_rd = 5; tick();
    clr(); tick();
    clr(); u.in_valid = 1; u.in_rs2 = 5; tick();
    chk("mem_data", u.data, 1'b1);
    chk("mem_fwrd", u.fwrd, 1'b1);
    clr(); u.in_valid = 1; u.in_rd = 0; tick();
    clr(); u.in_valid = 1; u.in_rs1 = 0; tick();
    chk("r0_data", u.data, 1'b0);
    clr(); tick(); tick(); tick();
    clr(); u.in_valid = 1; u.in_mul = 1; tick();
    clr(); u.in_valid = 1; u.in_mul = 1; tick();
    chk("mul_next_str", u.str, 1'b1);
    clr(); tick(); tick();
    clr(); u.in_valid = 1; u.in_mul = 1; tick();
    chk("mul_lat_str", u.str, 1'b0);
    clr(); tick(); tick(); tick();
    clr(); u.in_valid = 1; u.in_branch = 1; u.in_pred = 1; tick();
    chk("br_ctrl1", u.ctrl, 1'b1);
    clr(); tick();
    chk("br_ctrl2", u.ctrl, 1'b1);
    clr(); u.res_valid = 1; u.res_taken = 0; tick();
    chk("br_res_ctrl", u.ctrl, 1'b1);
    chk("br_res_branch", u.branch, 1'b1);
    chk("br_res_crct", u.crct, 1'b0);
    clr(); tick();
    chk("br_after_ctrl", u.ctrl, 1'b0);
    chk("br_after_branch", u.branch, 1'b0);
    clr(); u.in_valid = 1; u.in_branch = 1; u.in_pred = 1; u.in_rd = 2; tick();
    clr(); u.flush = 1; u.res_valid = 1; u.res_taken = 1; tick();
    chk("fl_branch", u.branch, 1'b1);
    chk("fl_crct", u.crct, 1'b1);
    clr(); u.in_valid = 1; u.in_rs1 = 2; tick();
    chk("fl_data", u.data, 1'b0);
    chk("fl_ctrl", u.ctrl, 1'b0);
    clr(); u.in_valid = 1; u.in_mul = 1; u.in_branch = 1; tick();
    clr(); rst_n = 0; u.res_valid = 1; u.flush = 1; tick();
    chk("rst_mid_ctrl", u.ctrl, 1'b0);
    chk("rst_mid_branch", u.branch, 1'b0);
    rst_n = 1;
    clr(); u.in_valid = 1; u.in_mul = 1; tick();
    chk("rst_mul_str", u.str, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(63) != 0);
      u.in_valid = ($urandom_range(9) < 7);
      u.in_rd = 3'($urandom_range(7));
      u.in_rs1 = 3'($urandom_range(7));
      u.in_rs2 = 3'($urandom_range(7));
      u.in_load = ($urandom_range(2) == 0);
      u.in_mul = ($urandom_range(3) == 0);
      u.in_branch = ($urandom_range(3) == 0);
      u.in_pred = 1'($urandom_range(1));
      u.res_valid = ($urandom_range(3) == 0);
      u.res_taken = 1'($urandom_range(1));
      u.freeze = ($urandom_range(7) == 0);
      u.flush = ($urandom_range(15) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
